// File: rtl/tank_pkg.sv
// Shared types and constants for the tank fire path: FSM states, key codes,
// default timing values and the free-slot priority encoder.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } fire_state_t;

  localparam logic [7:0] KEY_SPACE       = 8'h2C;
  localparam int         DEF_COOLDOWN    = 15;
  localparam int         DEF_ACK_TIMEOUT = 4;
  localparam int         MAX_BULLETS     = 8;
  localparam int         SLOT_W          = $clog2(MAX_BULLETS);

  typedef struct packed {
    logic              found;
    logic [SLOT_W-1:0] idx;
  } slot_sel_t;

  // Lowest-index inactive slot. Unused upper slots must be presented as
  // active by the caller so they are never selected.
  function automatic slot_sel_t first_free(input logic [MAX_BULLETS-1:0] active);
    slot_sel_t sel;
    sel.found = 1'b0;
    sel.idx   = '0;
    for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        sel.found = 1'b1;
        sel.idx   = SLOT_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/bullet_fire_ctrl_fire_key_detect.sv
// Fire key detector: matches any of the four keycode bytes against the fire
// key and keeps last frame's result to produce a press edge.
module fire_key_detect
  import tank_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY = KEY_SPACE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_keycode,
  output logic        o_fire_now,
  output logic        o_fire_edge
);

  logic w_match;
  logic r_fire_prev;

  // Any of the four simultaneous key slots may carry the fire key.
  always_comb begin
    w_match = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (i_keycode[8*b +: 8] == FIRE_KEY) begin
        w_match = 1'b1;
      end
    end
  end

  // Track the key every frame, whatever the controller is doing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fire_prev <= 1'b0;
    end else begin
      r_fire_prev <= w_match;
    end
  end

  assign o_fire_now  = w_match;
  assign o_fire_edge = w_match & ~r_fire_prev;

endmodule

// File: rtl/bullet_fire_ctrl.sv
// Per-tank fire controller: turns a fire key press into a one-hot create
// request to the lowest free bullet slot, holds it until that slot reports
// active (or a timeout expires), then enforces a cooldown.
// Optional build macro BULLET_AUTOFIRE_EN: trigger on the key level instead
// of the press edge, so a held key refires after every cooldown.
module bullet_fire_ctrl
  import tank_pkg::*;
#(
  parameter int         N_BULLETS   = 5,
  parameter logic [7:0] FIRE_KEY    = KEY_SPACE,
  parameter int         COOLDOWN    = DEF_COOLDOWN,
  parameter int         ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [31:0]          keycode,
  input  logic [N_BULLETS-1:0] bullet_active,
  output logic [N_BULLETS-1:0] create,
  output logic                 fire_ready,
  output logic [7:0]           shots_fired,
  output logic [3:0]           aborts
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT);
  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  fire_state_t            r_state;
  fire_state_t            w_state_nxt;
  logic [N_BULLETS-1:0]   r_create;
  logic [N_BULLETS-1:0]   w_create_nxt;
  logic [N_BULLETS-1:0]   w_onehot;
  logic [SLOT_W-1:0]      r_slot;
  logic [SLOT_W-1:0]      w_slot_nxt;
  logic [TMR_W-1:0]       r_tmr;
  logic [TMR_W-1:0]       w_tmr_nxt;
  logic [CD_W-1:0]        r_cd;
  logic [CD_W-1:0]        w_cd_nxt;
  logic [7:0]             r_shots;
  logic [3:0]             r_aborts;
  logic                   w_shot_inc;
  logic                   w_abort_inc;
  logic [MAX_BULLETS-1:0] w_act_pad;
  slot_sel_t              w_sel;
  logic                   w_fire_now;
  logic                   w_fire_edge;
  logic                   w_trig;

  fire_key_detect #(
    .FIRE_KEY (FIRE_KEY)
  ) u_key (
    .i_clk       (frame_clk),
    .i_rst       (Reset),
    .i_keycode   (keycode),
    .o_fire_now  (w_fire_now),
    .o_fire_edge (w_fire_edge)
  );

`ifdef BULLET_AUTOFIRE_EN
  // Level trigger; an edge always implies the key is down, so this is fire_now.
  assign w_trig = w_fire_now | w_fire_edge;
`else
  // Edge trigger; an edge already implies the key is down, so this is fire_edge.
  assign w_trig = w_fire_edge & w_fire_now;
`endif

  // Pad the pool to the package maximum with unusable (active) slots, then
  // pick the lowest free one and build its one-hot request.
  always_comb begin
    w_act_pad                  = '1;
    w_act_pad[N_BULLETS-1:0]   = bullet_active;
    w_sel                      = first_free(w_act_pad);
    w_onehot                   = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      w_onehot[i] = (w_sel.idx == SLOT_W'(i));
    end
  end

  // FSM state register.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= tank_pkg::IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-value logic for the request, timers and counter strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_create_nxt = r_create;
    w_slot_nxt   = r_slot;
    w_tmr_nxt    = r_tmr;
    w_cd_nxt     = r_cd;
    w_shot_inc   = 1'b0;
    w_abort_inc  = 1'b0;
    case (r_state)
      tank_pkg::IDLE: begin
        if (w_trig && w_sel.found) begin
          w_state_nxt  = tank_pkg::ISSUE;
          w_create_nxt = w_onehot;
          w_slot_nxt   = w_sel.idx;
          w_tmr_nxt    = '0;
        end
      end
      tank_pkg::ISSUE: begin
        // Only the slot we asked for counts as an acknowledge.
        if (w_act_pad[r_slot]) begin
          w_state_nxt  = tank_pkg::COOLDOWN;
          w_create_nxt = '0;
          w_shot_inc   = 1'b1;
          w_cd_nxt     = CD_W'(COOLDOWN - 1);
        end else if (r_tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
          w_state_nxt  = tank_pkg::COOLDOWN;
          w_create_nxt = '0;
          w_abort_inc  = 1'b1;
          w_cd_nxt     = CD_W'(COOLDOWN - 1);
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      tank_pkg::COOLDOWN: begin
        if (r_cd == '0) begin
          w_state_nxt = tank_pkg::IDLE;
        end else begin
          w_cd_nxt = r_cd - CD_W'(1);
        end
      end
      default: begin
        w_state_nxt  = tank_pkg::IDLE;
        w_create_nxt = '0;
      end
    endcase
  end

  // Request, slot latch and timers; reset drops create asynchronously.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_create <= '0;
      r_slot   <= '0;
      r_tmr    <= '0;
      r_cd     <= '0;
    end else begin
      r_create <= w_create_nxt;
      r_slot   <= w_slot_nxt;
      r_tmr    <= w_tmr_nxt;
      r_cd     <= w_cd_nxt;
    end
  end

  // Shot counter wraps; abort counter saturates at 15.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_shots  <= '0;
      r_aborts <= '0;
    end else begin
      if (w_shot_inc) begin
        r_shots <= r_shots + 8'd1;
      end
      if (w_abort_inc && (r_aborts != 4'hF)) begin
        r_aborts <= r_aborts + 4'd1;
      end
    end
  end

  assign create      = r_create;
  assign shots_fired = r_shots;
  assign aborts      = r_aborts;
  assign fire_ready  = (r_state == tank_pkg::IDLE) && w_sel.found;

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// Directed bench for bullet_fire_ctrl with a simple bullet-pool model: a slot
// registers create one frame, becomes active the next, and stays active until
// the bench kills it.
module tb_bullet_fire_ctrl;

  localparam logic [31:0] KEY_B0 = 32'h0000_002C;
  localparam logic [31:0] KEY_B1 = 32'h0000_2C00;
  localparam logic [31:0] KEY_B2 = 32'h002C_0000;
  localparam logic [31:0] KEY_B3 = 32'h2C00_0000;

  logic        Reset;
  logic        frame_clk;
  logic [31:0] keycode;
  logic [4:0]  bullet_active;
  logic [4:0]  create;
  logic        fire_ready;
  logic [7:0]  shots_fired;
  logic [3:0]  aborts;

  logic [4:0]  m_stage;
  logic [4:0]  m_act;
  logic [4:0]  force_mask;
  logic [4:0]  kill;
  logic        ack_en;

  int n_vec  = 0;
  int n_miss = 0;

  bullet_fire_ctrl dut (
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .keycode       (keycode),
    .bullet_active (bullet_active),
    .create        (create),
    .fire_ready    (fire_ready),
    .shots_fired   (shots_fired),
    .aborts        (aborts)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Bullet pool model
  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_stage <= '0;
      m_act   <= '0;
    end else begin
      m_stage <= create & {5{ack_en}};
      m_act   <= (m_act | m_stage) & ~kill;
    end
  end
  assign bullet_active = m_act | force_mask;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  // Release key, kill every bullet and let any cooldown expire.
  task automatic settle();
    keycode = '0;
    kill    = '1;
    tick(1);
    kill    = '0;
    tick(22);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int edges;
    logic [4:0] prev;

    Reset      = 1'b1;
    keycode    = '0;
    force_mask = '0;
    kill       = '0;
    ack_en     = 1'b1;
    tick(2);
    check_val("rst_create", create, 5'b00000);
    check_val("rst_shots", shots_fired, 8'd0);
    check_val("rst_aborts", aborts, 4'd0);
    check_val("rst_ready", fire_ready, 1'b1);
    Reset = 1'b0;
    tick(2);

    // Non-fire keys do nothing
    keycode = 32'h2D2B_2A29;
    tick(3);
    check_val("nokey_create", create, 5'b00000);
    keycode = '0;
    tick(1);

    // Single shot, key in byte 2
    keycode = KEY_B2;
    tick(1);
    check_val("ss_create_t0", create, 5'b00001);
    check_val("ss_ready_issue", fire_ready, 1'b0);
    tick(1);
    check_val("ss_create_t1", create, 5'b00001);
    tick(1);
    check_val("ss_create_t2", create, 5'b00001);
    tick(1);
    check_val("ss_create_t3", create, 5'b00000);
    check_val("ss_shots", shots_fired, 8'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (fire_ready) break;
      cnt++;
      tick(1);
    end
    check_val("ss_cooldown_frames", cnt, 15);
    settle();

    // Slot selection
    force_mask = 5'b01011;
    keycode    = KEY_B1;
    tick(1);
    check_val("sel_create", create, 5'b00100);
    settle();
    force_mask = '0;

    // Pool full
    force_mask = 5'b11111;
    tick(1);
    check_val("full_ready", fire_ready, 1'b0);
    keycode = KEY_B0;
    tick(1);
    check_val("full_create_t0", create, 5'b00000);
    tick(3);
    check_val("full_create_t3", create, 5'b00000);
    check_val("full_shots", shots_fired, 8'd2);
    check_val("full_aborts", aborts, 4'd0);
    force_mask = '0;
    settle();

    // Held key: one shot per press
    keycode = KEY_B3;
    edges   = 0;
    prev    = '0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (create != 5'b00000 && prev == 5'b00000) edges++;
      prev = create;
    end
    check_val("held_creates", edges, 1);
    keycode = '0;
    tick(1);
    keycode = KEY_B3;
    tick(1);
    check_val("repress_create", create, 5'b00010);
    tick(3);
    check_val("repress_shots", shots_fired, 8'd4);
    settle();

    // Timeout: slot never acknowledges
    ack_en  = 1'b0;
    keycode = KEY_B0;
    cnt     = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (create != 5'b00000) cnt++;
    end
    check_val("to_create_frames", cnt, 4);
    check_val("to_aborts", aborts, 4'd1);
    check_val("to_shots", shots_fired, 8'd4);
    for (int i = 0; i < 15; i++) begin
      keycode = '0;
      tick(1);
      keycode = KEY_B0;
      tick(22);
    end
    check_val("to_aborts_sat", aborts, 4'd15);
    check_val("to_shots_after", shots_fired, 8'd4);
    ack_en = 1'b1;
    settle();

    // Wrap: reset, then 256 acknowledged shots
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    tick(1);
    for (int i = 0; i < 256; i++) begin
      kill    = '1;
      keycode = '0;
      tick(1);
      kill    = '0;
      keycode = KEY_B2;
      tick(20);
      if (i == 254) check_val("wrap_shots_255", shots_fired, 8'd255);
    end
    check_val("wrap_shots_0", shots_fired, 8'd0);
    check_val("wrap_aborts", aborts, 4'd0);
    settle();

    // Reset while create is high
    keycode = KEY_B0;
    tick(2);
    check_val("mid_create_before", create, 5'b00001);
    Reset = 1'b1;
    #1;
    check_val("mid_create_async", create, 5'b00000);
    check_val("mid_shots", shots_fired, 8'd0);
    check_val("mid_ready", fire_ready, 1'b1);
    tick(1);
    Reset = 1'b0;
    tick(1);
    check_val("mid_refire", create, 5'b00001);
    tick(3);
    check_val("mid_refire_shots", shots_fired, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
